// File: rtl/prio_encoder_q.sv
// Registered priority encoder: latches active-low requests and hands them out one index at a time.
// Define PRIO_RR_EN for round-robin selection instead of fixed highest-index-first priority.
module prio_encoder_q #(
  parameter int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in,
  input  logic         ei,
  output logic [W-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic         gs,
  output logic         eo,
  output logic         ovf
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] cap, clr;
  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         eo_q, eo_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] sel;
  logic         load;

  function automatic logic [W-1:0] hi_idx(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

`ifdef PRIO_RR_EN
  logic [W-1:0] last_q, last_d;
  logic [N-1:0] below_last;

  // Indices below last are searched first (last-1 down to 0), then the wrap from N-1 down to last.
  always_comb begin
    below_last = '0;
    for (int i = 0; i < N; i++) begin
      below_last[i] = (W'(i) < last_q);
    end
    if (|(pend_q & below_last)) begin
      sel = hi_idx(pend_q & below_last);
    end else begin
      sel = hi_idx(pend_q);
    end
  end

  always_comb begin
    last_d = last_q;
    if (load) last_d = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    sel = hi_idx(pend_q);
  end
`endif

  always_comb begin
    cap     = ei ? '0 : ~data_in;
    clr     = '0;
    load    = 1'b0;
    state_d = state_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) load = 1'b1;
      end
      StHold: begin
        if (ready) begin
          if (|pend_q) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
    if (load) begin
      dout_d  = sel;
      clr     = {{(N-1){1'b0}}, 1'b1} << sel;
      valid_d = 1'b1;
      state_d = StHold;
    end
    // A capture landing on a bit being cleared this cycle is a fresh request, not an overflow.
    pend_d = (pend_q & ~clr) | cap;
    ovf_d  = ovf_q | (|(cap & pend_q & ~clr));
    eo_d   = ~(~ei & (&data_in) & ~(|pend_q) & (state_q == StIdle));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      eo_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      eo_q    <= eo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign gs    = ~valid_q;
  assign eo    = eo_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Scoreboard bench for prio_encoder_q: a transaction-level model predicts each presented index.
// Build with PRIO_RR_EN defined to check the round-robin variant.
module tb_prio_encoder_q;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] data_in = '0;
  logic         ei = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] dout;
  logic         valid, gs, eo, ovf;

  always #5 clk = ~clk;

  prio_encoder_q #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .data_in(data_in),
    .ei     (ei),
    .dout   (dout),
    .valid  (valid),
    .ready  (ready),
    .gs     (gs),
    .eo     (eo),
    .ovf    (ovf)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: pending set, whether something is on offer, sticky overflow, eo, rr pointer.
  bit m_pend[N];
  bit m_busy = 1'b0;
  bit m_ovf = 1'b0;
  bit m_eo = 1'b1;
  bit m_rst_seen = 1'b0;
  int m_last = 0;
  int exp_q[$];
  int acc_log[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int start;
`ifdef PRIO_RR_EN
    start = (m_last + N - 1) % N;
`else
    start = N - 1;
`endif
    for (int k = 0; k < N; k++) begin
      int idx = (start - k + N) % N;
      if (m_pend[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int log_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int  win;
    bit  any;
    bit  eo_n;
    bit  c;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_busy = 1'b0;
      m_ovf = 1'b0;
      m_eo = 1'b1;
      m_last = 0;
      m_rst_seen = 1'b1;
      exp_q.delete();
    end else begin
      m_rst_seen = 1'b0;
      any = 1'b0;
      foreach (m_pend[i]) any |= m_pend[i];
      eo_n = !(!ei && (data_in == {N{1'b1}}) && !any && !m_busy);
      win = -1;
      if (!m_busy || ready) begin
        win = pick();
        if (win >= 0) begin
          exp_q.push_back(win);
          m_busy = 1'b1;
          m_last = win;
        end else begin
          m_busy = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        c = !ei && !data_in[i];
        if (c && m_pend[i] && i != win) m_ovf = 1'b1;
        m_pend[i] = (m_pend[i] && i != win) || c;
      end
      m_eo = eo_n;
    end
  end

  always @(negedge clk) begin : monitor
    check("valid", int'(valid), int'(m_busy));
    check("gs", int'(gs), int'(!m_busy));
    check("eo", int'(eo), int'(m_eo));
    check("ovf", int'(ovf), int'(m_ovf));
    if (m_rst_seen) check("dout_rst", int'(dout), 0);
    if (valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dout_unexpected: got %0d, expected no output (t=%0t)", dout, $time);
      end else begin
        check("dout", int'(dout), exp_q[0]);
        if (ready && !rst) begin
          acc_log.push_back(int'(dout));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic [N-1:0] d, input logic e, input logic r, input logic rs);
    data_in = d;
    ei = e;
    ready = r;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] d;

    // Reset with every line requesting: nothing may be captured.
    repeat (3) drive('0, 1'b0, 1'b0, 1'b1);

    acc_log.delete();
    drive(8'b0101_1110, 1'b0, 1'b1, 1'b0);
    repeat (6) drive('1, 1'b0, 1'b1, 1'b0);
    check("burst0", log_at(0), 7);
    check("burst1", log_at(1), 5);
    check("burst2", log_at(2), 0);
    check("burst_len", acc_log.size(), 3);

    acc_log.delete();
    drive(~8'b0000_1010, 1'b0, 1'b0, 1'b0);
    repeat (5) drive('1, 1'b0, 1'b0, 1'b0);
    check("bp_hold_dout", int'(dout), 3);
    check("bp_hold_valid", int'(valid), 1);
    repeat (4) drive('1, 1'b0, 1'b1, 1'b0);
    check("bp0", log_at(0), 3);
    check("bp1", log_at(1), 1);
    check("bp_idle", int'(valid), 0);

    // Same-cycle capture and clear on line 2.
    drive('1, 1'b0, 1'b0, 1'b1);
    acc_log.delete();
    drive(~8'b0000_0100, 1'b0, 1'b0, 1'b0);
    drive(~8'b0000_0100, 1'b0, 1'b0, 1'b0);
    repeat (2) drive('1, 1'b0, 1'b0, 1'b0);
    repeat (5) drive('1, 1'b0, 1'b1, 1'b0);
    check("same0", log_at(0), 2);
    check("same1", log_at(1), 2);
    check("same_ovf", int'(ovf), 0);

    // Line 2 recaptured while still pending behind line 7.
    drive(~8'b1000_0100, 1'b0, 1'b0, 1'b0);
    drive('1, 1'b0, 1'b0, 1'b0);
    drive(~8'b0000_0100, 1'b0, 1'b0, 1'b0);
    drive('1, 1'b0, 1'b0, 1'b0);
    check("ovf_set", int'(ovf), 1);
    repeat (6) drive('1, 1'b0, 1'b1, 1'b0);
    check("ovf_sticky", int'(ovf), 1);

    drive('1, 1'b0, 1'b0, 1'b1);
    repeat (3) drive('0, 1'b1, 1'b1, 1'b0);
    check("ei_eo", int'(eo), 1);
    check("ei_valid", int'(valid), 0);
    repeat (2) drive('1, 1'b0, 1'b1, 1'b0);
    check("eo_low", int'(eo), 0);
    check("ei_valid2", int'(valid), 0);

    drive('1, 1'b0, 1'b0, 1'b1);
    acc_log.delete();
    repeat (8) drive(~8'b0100_0010, 1'b0, 1'b1, 1'b0);
    repeat (6) drive('1, 1'b0, 1'b1, 1'b0);
    check("hold0", log_at(0), 6);
`ifdef PRIO_RR_EN
    check("hold1", log_at(1), 1);
    check("hold2", log_at(2), 6);
    check("hold3", log_at(3), 1);
`else
    check("hold1", log_at(1), 6);
    check("hold2", log_at(2), 6);
    check("hold3", log_at(3), 6);
`endif

    for (int cyc = 0; cyc < 3000; cyc++) begin
      d = '1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) d[i] = 1'b0;
      end
      drive(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 199) == 0));
    end

    repeat (20) drive('1, 1'b0, 1'b1, 1'b0);
    check("sb_empty", exp_q.size(), 0);
    check("drain_valid", int'(valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
